io_led_driver: RTL and testbench

//  Drives the active-low power LED line (_LED) that feeds the LED output model.

---
 rtl/io_led_pkg.sv | 24 ++
 rtl/io_led_ticker.sv | 33 +++
 rtl/io_led_driver.sv | 157 +++++++++++++++
 tb/tb_io_led_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_led_pkg.sv
// Purpose : shared types and constants for the power-LED driver.
//   led_state_t - LED drive mode, encoded as reported on LED_STATE
//   PA_LED_BIT  - bit of CIA-A PRA that carries the LED / filter control
//   base_state  - steady-state LED mode from the effective PA1 and the dim enable
package io_led_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        BRIGHT   = 2'd1,
        DIM      = 2'd2,
        ACTIVITY = 2'd3
    } led_state_t;

    localparam int PA_LED_BIT = 1;

    // PA1 low lights the LED fully; PA1 high gives dim or off.
    function automatic led_state_t base_state(input logic eff_pa1, input logic dim_en);
        if (!eff_pa1) begin
            return BRIGHT;
        end
        return dim_en ? DIM : OFF;
    endfunction

endpackage

// File: rtl/io_led_ticker.sv
// Purpose : free-running prescaler that emits a one-cycle tick every PRESCALE clocks.
// Ports   :
//   i_clk   in  1  system clock
//   i_rst_n in  1  asynchronous active-low reset
//   o_tick  out 1  high on the cycle the prescaler wraps (count == PRESCALE-1)
module io_led_ticker #(
    parameter int PRESCALE = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(PRESCALE - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = w_wrap;

endmodule

// File: rtl/io_led_driver.sv
// Purpose : drives the active-low power LED from CIA-A PA1, with a PWM dim mode
//           for PA1=1 and a blinking, retriggerable drive-activity overlay.
// Ports   :
//   CLK       in  1  system clock
//   _RESET    in  1  asynchronous active-low reset
//   PA_WE     in  1  one-cycle write strobe to CIA-A PRA
//   PA_D      in  8  PRA write data (only bit 1 is used)
//   DDR_OUT   in  1  DDRA bit 1; 0 means PA1 floats high
//   DIM_EN    in  1  1 = PA1 high gives a dim LED instead of off
//   ACT       in  1  drive-activity level; rising edge starts/extends the overlay
//   _LED      out 1  registered LED drive, 0 = lit
//   LED_STATE out 2  current mode: 0 OFF, 1 BRIGHT, 2 DIM, 3 ACTIVITY
module io_led_driver
    import io_led_pkg::*;
#(
    parameter int PRESCALE      = 256,
    parameter int PWM_BITS      = 4,
    parameter int DIM_DUTY      = 4,
    parameter int STRETCH_TICKS = 1024,
    parameter int BLINK_TICKS   = 64
) (
    input  logic       CLK,
    input  logic       _RESET,
    input  logic       PA_WE,
    input  logic [7:0] PA_D,
    input  logic       DDR_OUT,
    input  logic       DIM_EN,
    input  logic       ACT,
    output logic       _LED,
    output logic [1:0] LED_STATE
);

    localparam int          STR_W      = $clog2(STRETCH_TICKS + 1);
    localparam int          BLK_W      = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [31:0] DIM_DUTY_U = 32'(DIM_DUTY);

    logic                r_pa1;
    logic                r_act_q;
    logic                r_led;
    logic                r_phase_lit;
    led_state_t          r_state;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [STR_W-1:0]    r_stretch;
    logic [BLK_W-1:0]    r_blink_cnt;

    led_state_t          w_state_nxt;
    logic [STR_W-1:0]    w_stretch_nxt;
    logic [BLK_W-1:0]    w_blink_nxt;
    logic                w_phase_nxt;
    logic                w_led_nxt;
    logic                w_tick;
    logic                w_eff_pa1;
    logic                w_act_rise;
    led_state_t          w_base;
    logic                w_unused_pa;

    // Only PA1 drives the LED; the other PRA bits belong to other functions.
    assign w_unused_pa = ^{PA_D[7:PA_LED_BIT+1], PA_D[PA_LED_BIT-1:0]};

    io_led_ticker #(
        .PRESCALE (PRESCALE)
    ) u_ticker (
        .i_clk   (CLK),
        .i_rst_n (_RESET),
        .o_tick  (w_tick)
    );

    // With the port bit configured as input the pull-up makes PA1 read as 1.
    assign w_eff_pa1  = DDR_OUT ? r_pa1 : 1'b1;
    assign w_base     = base_state(w_eff_pa1, DIM_EN);
    assign w_act_rise = ACT & ~r_act_q;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_pa1     <= 1'b1;
            r_act_q   <= 1'b0;
            r_pwm_cnt <= '0;
        end else begin
            r_act_q <= ACT;
            if (PA_WE) begin
                r_pa1 <= PA_D[PA_LED_BIT];
            end
            // PWM counter wraps naturally at 2**PWM_BITS.
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_state     <= OFF;
            r_stretch   <= '0;
            r_blink_cnt <= '0;
            r_phase_lit <= 1'b1;
            r_led       <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_stretch   <= w_stretch_nxt;
            r_blink_cnt <= w_blink_nxt;
            r_phase_lit <= w_phase_nxt;
            r_led       <= w_led_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_stretch_nxt = r_stretch;
        w_blink_nxt   = r_blink_cnt;
        w_phase_nxt   = r_phase_lit;

        if (r_state == ACTIVITY && w_tick) begin
            if (r_blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                w_blink_nxt = '0;
                w_phase_nxt = ~r_phase_lit;
            end else begin
                w_blink_nxt = r_blink_cnt + BLK_W'(1);
            end
        end

        if (w_act_rise) begin
            // A rising edge always (re)loads the stretch, even on the cycle
            // the timer would otherwise expire. A retrigger keeps the blink
            // running so the pattern stays continuous.
            w_state_nxt   = ACTIVITY;
            w_stretch_nxt = STR_W'(STRETCH_TICKS);
            if (r_state != ACTIVITY) begin
                w_blink_nxt = '0;
                w_phase_nxt = 1'b1;
            end
        end else if (r_state == ACTIVITY) begin
            if (w_tick) begin
                w_stretch_nxt = r_stretch - STR_W'(1);
                if (r_stretch == STR_W'(1)) begin
                    w_state_nxt = w_base;
                end
            end
        end else begin
            w_state_nxt = w_base;
        end
    end

    always_comb begin
        w_led_nxt = 1'b1;
        case (r_state)
            OFF:      w_led_nxt = 1'b1;
            BRIGHT:   w_led_nxt = 1'b0;
            DIM:      w_led_nxt = !(32'(r_pwm_cnt) < DIM_DUTY_U);
            ACTIVITY: w_led_nxt = ~r_phase_lit;
            default:  w_led_nxt = 1'b1;
        endcase
    end

    assign _LED      = r_led;
    assign LED_STATE = r_state;

endmodule

// File: tb/tb_io_led_driver.sv
// Purpose : self-checking bench for io_led_driver with small parameters.
//   A tick-arithmetic reference model predicts _LED and LED_STATE on every
//   cycle; directed scenarios add explicit latency, duty and duration checks,
//   followed by randomized stimulus.
module tb_io_led_driver;

    localparam int P     = 4;
    localparam int PWMB  = 2;
    localparam int DUTY  = 1;
    localparam int STR   = 8;
    localparam int BLK   = 2;
    localparam int PWM_P = 1 << PWMB;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       PA_WE = 1'b0;
    logic [7:0] PA_D = 8'h00;
    logic       DDR_OUT = 1'b0;
    logic       DIM_EN = 1'b0;
    logic       ACT = 1'b0;
    logic       led;
    logic [1:0] led_state;

    int n_checks = 0;
    int n_errors = 0;

    io_led_driver #(
        .PRESCALE      (P),
        .PWM_BITS      (PWMB),
        .DIM_DUTY      (DUTY),
        .STRETCH_TICKS (STR),
        .BLINK_TICKS   (BLK)
    ) dut (
        .CLK       (CLK),
        ._RESET    (rst_n),
        .PA_WE     (PA_WE),
        .PA_D      (PA_D),
        .DDR_OUT   (DDR_OUT),
        .DIM_EN    (DIM_EN),
        .ACT       (ACT),
        ._LED      (led),
        .LED_STATE (led_state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time is counted in clock edges since reset release (m_k). Edge e is a
    // tick edge when e % P == P-1, so e/P ticks precede edge e and (e+1)/P
    // ticks have happened once edge e is done. Activity expiry and blink
    // phase are expressed as tick counts relative to trigger / entry.
    int m_k     = 0;
    int m_state = 0;
    int m_led   = 1;
    int m_entry = 0;
    int m_exit  = 0;
    bit m_pa1   = 1'b1;
    bit m_act_q = 1'b0;

    function automatic int f_base(bit pa1, bit ddr, bit dim);
        bit eff;
        eff = ddr ? pa1 : 1'b1;
        if (!eff) return 1;
        return dim ? 2 : 0;
    endfunction

    function automatic int f_led(int st, int e, int entry);
        int n;
        case (st)
            0: return 1;
            1: return 0;
            2: return (((e / P) % PWM_P) < DUTY) ? 0 : 1;
            default: begin
                n = (e / P) - entry;
                return (((n / BLK) % 2) == 0) ? 0 : 1;
            end
        endcase
    endfunction

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_k     <= 0;
            m_state <= 0;
            m_led   <= 1;
            m_entry <= 0;
            m_exit  <= 0;
            m_pa1   <= 1'b1;
            m_act_q <= 1'b0;
        end else begin
            m_k     <= m_k + 1;
            m_act_q <= ACT;
            if (PA_WE) m_pa1 <= PA_D[1];
            m_led <= f_led(m_state, m_k, m_entry);
            if (ACT && !m_act_q) begin
                if (m_state != 3) m_entry <= (m_k + 1) / P;
                m_exit  <= (m_k + 1) / P + STR;
                m_state <= 3;
            end else if (m_state == 3) begin
                if ((m_k % P == P - 1) && ((m_k + 1) / P == m_exit))
                    m_state <= f_base(m_pa1, DDR_OUT, DIM_EN);
            end else begin
                m_state <= f_base(m_pa1, DDR_OUT, DIM_EN);
            end
        end
    end

    always @(negedge CLK) begin
        chk("model_led", led, m_led);
        chk("model_state", led_state, m_state);
    end

    // ---------------- stimulus helpers ----------------
    task automatic pa_write(input logic [7:0] d);
        PA_WE = 1'b1;
        PA_D  = d;
        @(negedge CLK);
        PA_WE = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int start, input int lim, output int n);
        n = start;
        while (led_state != s && n < lim) begin
            @(negedge CLK);
            n++;
        end
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if ($urandom_range(15) == 0) begin
                PA_WE = 1'b1;
                PA_D  = 8'($urandom);
            end else begin
                PA_WE = 1'b0;
            end
            if ($urandom_range(31) == 0) DDR_OUT = ($urandom_range(7) != 0);
            if ($urandom_range(31) == 0) DIM_EN = ~DIM_EN;
            if ($urandom_range(23) == 0) ACT = ~ACT;
        end
        @(negedge CLK);
        PA_WE = 1'b0;
    endtask

    initial begin
        int n;
        int lows;

        repeat (3) @(negedge CLK);
        rst_n = 1'b1;

        // idle after reset with PA1 undriven
        repeat (20) @(negedge CLK);
        chk("idle_state", led_state, 0);
        chk("idle_led", led, 1);

        // PA1 written low: state one edge later, LED one more
        DDR_OUT = 1'b1;
        pa_write(8'h00);
        chk("pa_n_state", led_state, 0);
        @(negedge CLK);
        chk("pa_n1_state", led_state, 1);
        chk("pa_n1_led", led, 1);
        @(negedge CLK);
        chk("pa_n2_led", led, 0);
        pa_write(8'hFD);
        repeat (3) @(negedge CLK);
        chk("pa_fd_state", led_state, 1);

        // dim duty
        DIM_EN = 1'b1;
        pa_write(8'h02);
        repeat (3) @(negedge CLK);
        chk("dim_state", led_state, 2);
        lows = 0;
        repeat (16) begin
            @(negedge CLK);
            if (!led) lows++;
        end
        chk("dim_lows16", lows, 4);
        DIM_EN = 1'b0;
        repeat (2) @(negedge CLK);
        chk("dimoff_led", led, 1);
        chk("dimoff_state", led_state, 0);

        // activity from BRIGHT, ACT held high afterwards
        pa_write(8'h00);
        repeat (3) @(negedge CLK);
        ACT = 1'b1;
        @(negedge CLK);
        chk("act_state", led_state, 3);
        @(negedge CLK);
        chk("act_lit", led, 0);
        wait_state(2'd1, 2, 100, n);
        chk("act_len_28_36", int'(n >= 28 && n <= 36), 1);

        // retrigger 20 clocks after the first rise
        ACT = 1'b0;
        repeat (2) @(negedge CLK);
        ACT = 1'b1;
        n = 0;
        repeat (10) begin @(negedge CLK); n++; end
        ACT = 1'b0;
        repeat (10) begin @(negedge CLK); n++; end
        ACT = 1'b1;
        wait_state(2'd1, n, 150, n);
        chk("retrig_len_48_56", int'(n >= 48 && n <= 56), 1);

        // simultaneous PA write and activity rise from OFF
        pa_write(8'h02);
        ACT = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pre_sim_off", led_state, 0);
        PA_WE = 1'b1;
        PA_D  = 8'h00;
        ACT   = 1'b1;
        @(negedge CLK);
        PA_WE = 1'b0;
        chk("sim_act", led_state, 3);
        wait_state(2'd1, 0, 60, n);
        chk("sim_exit_bright", led_state, 1);
        DDR_OUT = 1'b0;
        repeat (2) @(negedge CLK);
        chk("ddr_off", led_state, 0);

        random_run(3000);

        // asynchronous reset mid-run, between clock edges
        ACT     = 1'b0;
        DIM_EN  = 1'b0;
        DDR_OUT = 1'b1;
        pa_write(8'h00);
        repeat (40) @(negedge CLK);
        chk("pre_rst_bright", led_state, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_led", led, 1);
        chk("rst_state", led_state, 0);
        DDR_OUT = 1'b0;
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        repeat (40) @(negedge CLK);
        chk("post_rst_off", led_state, 0);

        random_run(2000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
